// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the two-client RAM port arbiter.
// FSM states are used only when RAM_ARB_INIT_EN is defined.
package ram_port_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam logic CID_0 = 1'b0;
  localparam logic CID_1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on contention the client not granted last wins.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (last == CID_1) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two clients, one access per clock.
// Define RAM_ARB_INIT_EN to zero-fill the RAM after reset before arbitration starts.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  logic [1:0]        gnt;
  logic              sel;
  logic              sel_we;
  logic              last_gnt;
  logic              rd_vld;
  logic              rd_id;
  logic [DATA_W-1:0] c0_hold, c1_hold;

`ifdef RAM_ARB_INIT_EN
  arb_state_e        state;
  logic [ADDR_W:0]   init_cnt;
`else
  assign busy = 1'b0;
`endif

  rr_arb2 u_arb (
    .req  ({c1_req, c0_req}),
    .en   (!busy),
    .last (last_gnt),
    .gnt  (gnt)
  );

  assign c0_gnt = gnt[0];
  assign c1_gnt = gnt[1];
  assign sel    = gnt[1];
  assign sel_we = sel ? c1_we : c0_we;

  // RAM data lands the cycle rvalid is high; the hold register keeps it afterwards.
  assign c0_rdata = c0_rvalid ? ram_rdata : c0_hold;
  assign c1_rdata = c1_rvalid ? ram_rdata : c1_hold;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_gnt  <= CID_1;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_vld    <= 1'b0;
      rd_id     <= CID_0;
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c0_hold   <= '0;
      c1_hold   <= '0;
`ifdef RAM_ARB_INIT_EN
      state     <= ST_INIT;
      init_cnt  <= '0;
      busy      <= 1'b1;
`endif
    end else begin
      if (|gnt) last_gnt <= sel;
      ram_en    <= |gnt;
      ram_we    <= (|gnt) && sel_we;
      ram_addr  <= sel ? c1_addr  : c0_addr;
      ram_wdata <= sel ? c1_wdata : c0_wdata;
      rd_vld    <= (|gnt) && !sel_we;
      rd_id     <= sel;
      c0_rvalid <= rd_vld && (rd_id == CID_0);
      c1_rvalid <= rd_vld && (rd_id == CID_1);
      if (c0_rvalid) c0_hold <= ram_rdata;
      if (c1_rvalid) c1_hold <= ram_rdata;
`ifdef RAM_ARB_INIT_EN
      // Grants are forced low while busy, so the init writes own the command register.
      if (state == ST_INIT) begin
        if (init_cnt[ADDR_W]) begin
          state  <= ST_RUN;
          busy   <= 1'b0;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end else begin
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= init_cnt[ADDR_W-1:0];
          ram_wdata <= '0;
          init_cnt  <= init_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
